// File: rtl/ntt_stage_scheduler.sv
// Address sequencer for an in-place radix-2 Cooley-Tukey NTT on a single pipelined butterfly.
// It issues read/twiddle addresses, delays them into write-back addresses and drains between stages.
module ntt_stage_scheduler #(
  parameter int LOGN    = 10,
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [LOGN-1:0]            rd_addr_a,
  output logic [LOGN-1:0]            rd_addr_b,
  output logic [LOGN-2:0]            tw_addr,
  output logic                       wr_en,
  output logic [LOGN-1:0]            wr_addr_a,
  output logic [LOGN-1:0]            wr_addr_b,
  output logic [$clog2(LOGN+1)-1:0]  stage_idx
);

  localparam int PIPE = MEM_LAT + BF_LAT;
  localparam int SW   = $clog2(LOGN + 1);
  localparam int JW   = LOGN - 1;
  localparam int CW   = $clog2(PIPE + 1);

  localparam logic [JW-1:0] J_LAST     = '1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            rdEn_q;
  logic [LOGN-1:0] rdA_q, rdB_q;
  logic [JW-1:0]   tw_q;

  logic            pipeV_q [PIPE];
  logic [LOGN-1:0] pipeA_q [PIPE];
  logic [LOGN-1:0] pipeB_q [PIPE];

  logic [LOGN-1:0] jExt, span, pos, aNext, bNext;
  logic [JW-1:0]   twNext;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          j_d     = '0;
          stage_d = '0;
        end
      end
      ISSUE: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          cnt_d   = CW'(PIPE);
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      DRAIN: begin
        // Leaving on the last drain cycle lets the next stage's first read follow the last write directly.
        if (cnt_q <= CW'(1)) begin
          if (stage_q < LAST_STAGE) begin
            stage_d = stage_q + SW'(1);
            j_d     = '0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterfly j of stage s pairs (group*2^(s+1)+pos, +2^s); twiddle index scales pos to the full ROM.
  always_comb begin
    jExt   = {1'b0, j_d};
    span   = LOGN'(1) << stage_d;
    pos    = jExt & (span - LOGN'(1));
    aNext  = ((jExt >> stage_d) << (stage_d + SW'(1))) | pos;
    bNext  = aNext + span;
    twNext = JW'(pos << (SW'(LOGN - 1) - stage_d));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      rdEn_q  <= 1'b0;
      rdA_q   <= '0;
      rdB_q   <= '0;
      tw_q    <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pipeV_q[i] <= 1'b0;
        pipeA_q[i] <= '0;
        pipeB_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      rdEn_q  <= (state_d == ISSUE);
      rdA_q   <= (state_d == ISSUE) ? aNext  : '0;
      rdB_q   <= (state_d == ISSUE) ? bNext  : '0;
      tw_q    <= (state_d == ISSUE) ? twNext : '0;
      for (int i = PIPE - 1; i > 0; i--) begin
        pipeV_q[i] <= pipeV_q[i-1];
        pipeA_q[i] <= pipeA_q[i-1];
        pipeB_q[i] <= pipeB_q[i-1];
      end
      pipeV_q[0] <= rdEn_q;
      pipeA_q[0] <= rdA_q;
      pipeB_q[0] <= rdB_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rd_en     = rdEn_q;
  assign rd_addr_a = rdA_q;
  assign rd_addr_b = rdB_q;
  assign tw_addr   = tw_q;
  assign wr_en     = pipeV_q[PIPE-1];
  assign wr_addr_a = pipeA_q[PIPE-1];
  assign wr_addr_b = pipeB_q[PIPE-1];
  assign stage_idx = stage_q;

endmodule
